// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and width defaults for the memory arbiter slice
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and shared memory port bundle; slave = arbiter side
interface mem_arbiter_if import cpu_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rvalid, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: owner selection; MEM_ARBITER_RR_EN makes contention follow rr_ptr
module arb_pick import cpu_mem_pkg::*; (
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t rr_ptr,
  output owner_t pick
);
`ifdef MEM_ARBITER_RR_EN
  always_comb pick = (if_req && d_req) ? rr_ptr : (d_req ? OWN_D : OWN_IF);
`else
  always_comb pick = d_req ? OWN_D : (if_req ? OWN_IF : rr_ptr);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data requesters share one memory port, one transaction at a time
// MEM_ARBITER_RR_EN selects round-robin on contention instead of data-first priority
module mem_arbiter import cpu_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          sys_clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          stall,
  output logic          err_spurious
);
  state_t state, state_nx;
  owner_t owner, pick, rr_ptr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] be;
  logic we, any_req, acc, done;

  arb_pick u_pick (.if_req(bus.if_req), .d_req(bus.d_req), .rr_ptr(rr_ptr), .pick(pick));

  always_comb begin
    any_req  = bus.if_req || bus.d_req;
    acc      = state == ISSUE && bus.m_ready;
    done     = state == WAIT && bus.m_rvalid;
    state_nx = state == IDLE  ? (any_req ? ISSUE : IDLE) :
               state == ISSUE ? (bus.m_ready ? WAIT : ISSUE) :
                                (bus.m_rvalid ? IDLE : WAIT);
  end

  assign bus.m_req    = state == ISSUE;
  assign bus.m_we     = we;
  assign bus.m_addr   = addr;
  assign bus.m_wdata  = wdata;
  assign bus.m_be     = be;
  assign bus.if_gnt   = acc && owner == OWN_IF;
  assign bus.d_gnt    = acc && owner == OWN_D;
  assign bus.if_valid = done && owner == OWN_IF;
  assign bus.d_valid  = done && owner == OWN_D;
  assign bus.if_rdata = bus.if_valid ? bus.m_rdata : '0;
  assign bus.d_rdata  = (bus.d_valid && !we) ? bus.m_rdata : '0;
  assign stall        = (bus.if_req && !bus.if_valid) || (bus.d_req && !bus.d_valid);

  // a response outside WAIT (including one racing m_ready) has no transaction to belong to
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_D;
      addr         <= '0;
      wdata        <= '0;
      be           <= '0;
      we           <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.m_rvalid && state != WAIT) err_spurious <= 1'b1;
      if (state == IDLE && any_req) begin
        owner <= pick;
        addr  <= pick == OWN_D ? bus.d_addr : bus.if_addr;
        wdata <= pick == OWN_D ? bus.d_wdata : '0;
        be    <= pick == OWN_D ? bus.d_be : '1;
        we    <= pick == OWN_D && bus.d_we;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rr_ptr <= OWN_D;
    else if (done) rr_ptr <= owner == OWN_D ? OWN_IF : OWN_D;
  end
`else
  assign rr_ptr = OWN_D;
`endif
endmodule
